// File: rtl/beat_playback_scheduler_if.sv
// Beat/playback bus between the beat detector, the scheduler and the player.
//
// Handshake: play_req rises together with a valid play_level and both stay
// stable until play_ack is sampled high on a rising clk edge while play_req
// is high; that edge completes the transfer and play_req falls after it.
// play_ack sampled while play_req is low is ignored.
interface beat_playback_scheduler_if;
  logic       enable;
  logic       beat_en;
  logic [1:0] beat_intensity;
  logic       play_ack;
  logic       play_req;
  logic [1:0] play_level;
  logic       play_active;
  logic [2:0] fifo_count;
  logic       holdoff_busy;
  logic       overflow;
  logic [7:0] drop_count;
  logic [1:0] fsm_state;    // debug view of the playback FSM

  // Master: detector/player side driving the scheduler
  modport master (
    output enable, beat_en, beat_intensity, play_ack,
    input  play_req, play_level, play_active, fifo_count,
           holdoff_busy, overflow, drop_count, fsm_state
  );

  // Slave: the scheduler itself
  modport slave (
    input  enable, beat_en, beat_intensity, play_ack,
    output play_req, play_level, play_active, fifo_count,
           holdoff_busy, overflow, drop_count, fsm_state
  );
endinterface

// File: rtl/beat_playback_scheduler.sv
// Beat playback scheduler: edge-detects beats, rate-limits them with a
// refractory counter, queues them in a 4-deep FIFO and plays them out one at
// a time over a req/ack handshake with intensity-dependent durations.
module beat_playback_scheduler #(
  parameter logic [23:0] HOLDOFF_CYC = 24'd2500000,
  parameter logic [23:0] DUR_1       = 24'd5000000,
  parameter logic [23:0] DUR_2       = 24'd10000000,
  parameter logic [23:0] DUR_3       = 24'd15000000,
  parameter logic [23:0] GAP_CYC     = 24'd500000
) (
  input  logic                        clk,
  input  logic                        rst,
  beat_playback_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        beat_prev_q;
  logic [23:0] holdoff_q, holdoff_d;
  logic [1:0]  fifo_mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  drop_q, drop_d;
  logic        req_q;
  logic [1:0]  level_q;
  logic        active_q;
  logic [23:0] dur_q;

  logic beat_evt, hold_busy, fifo_full, take, push, drop, pop;

  // A beat is a rising edge of beat_en carrying a non-zero intensity
  assign beat_evt  = bus.beat_en & ~beat_prev_q & (bus.beat_intensity != 2'b00);
  assign hold_busy = (holdoff_q != 24'd0);
  assign fifo_full = (count_q == 3'd4);
  assign take      = beat_evt & bus.enable;
  assign push      = take & ~hold_busy & ~fifo_full;
  assign drop      = take & (hold_busy | fifo_full);
  assign pop       = (state_q == IDLE) & (count_q != 3'd0);

  function automatic logic [23:0] dur_for(input logic [1:0] lvl);
    case (lvl)
      2'b10:   return DUR_2;
      2'b11:   return DUR_3;
      default: return DUR_1;
    endcase
  endfunction

  // Next-state for holdoff counter, FIFO occupancy and drop bookkeeping
  always_comb begin
    holdoff_d  = holdoff_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push) begin
      holdoff_d = HOLDOFF_CYC;
    end else if (hold_busy) begin
      holdoff_d = holdoff_q - 24'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (take & ~hold_busy & fifo_full) begin
      overflow_d = 1'b1;
    end
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Edge register, holdoff counter, FIFO storage/pointers and drop stats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_prev_q <= 1'b0;
      holdoff_q   <= 24'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      overflow_q  <= 1'b0;
      drop_q      <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 2'b00;
      end
    end else begin
      beat_prev_q <= bus.beat_en;
      holdoff_q   <= holdoff_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= bus.beat_intensity;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

  // Playback FSM: pop, request, play for DUR_n, then a silent gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      level_q  <= 2'b00;
      active_q <= 1'b0;
      dur_q    <= 24'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            level_q <= fifo_mem_q[rd_ptr_q];
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.play_ack) begin
            req_q    <= 1'b0;
            active_q <= 1'b1;
            dur_q    <= dur_for(level_q);
            state_q  <= PLAY;
          end
        end
        PLAY: begin
          if (dur_q <= 24'd1) begin
            active_q <= 1'b0;
            dur_q    <= GAP_CYC;
            state_q  <= GAP;
          end else begin
            dur_q <= dur_q - 24'd1;
          end
        end
        GAP: begin
          if (dur_q <= 24'd1) begin
            state_q <= IDLE;
          end else begin
            dur_q <= dur_q - 24'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.play_req     = req_q;
  assign bus.play_level   = level_q;
  assign bus.play_active  = active_q;
  assign bus.fifo_count   = count_q;
  assign bus.holdoff_busy = hold_busy;
  assign bus.overflow     = overflow_q;
  assign bus.drop_count   = drop_q;
  assign bus.fsm_state    = state_q;

endmodule
